// File: rtl/prescaled_updown_counter_pkg.sv
// rtl/prescaled_updown_counter_pkg.sv - mode encodings shared by the counter and its bench
package prescaled_updown_counter_pkg;

    localparam logic [1:0] MODE_WRAP   = 2'b00;
    localparam logic [1:0] MODE_SAT    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

endpackage

// File: rtl/prescaled_updown_counter_tick_prescaler.sv
// rtl/prescaled_updown_counter_tick_prescaler.sv - divide-by-DIV enable tick generator
module tick_prescaler #(
    parameter int DIV = 7
) (
    input  logic clock,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_psc;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_psc <= '0;
        end else if (clr) begin
            r_psc <= '0;
        end else if (en) begin
            r_psc <= (r_psc == LAST) ? '0 : r_psc + PW'(1);
        end
    end

    // With DIV=1 LAST is 0 and r_psc never leaves 0, so tick simply follows en.
    assign tick = en && (r_psc == LAST);

endmodule

// File: rtl/prescaled_updown_counter.sv
// rtl/prescaled_updown_counter.sv - prescaled up/down counter with wrap, saturate and bounce modes
module prescaled_updown_counter
    import prescaled_updown_counter_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DIV   = 7
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             evt,
    output logic             dir_eff,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_evt;
    logic             r_bdir;

    logic             w_tick;
    logic             w_up;
    logic [WIDTH-1:0] w_next;
    logic             w_evt;
    logic             w_bdir_step;

    tick_prescaler #(.DIV(DIV)) u_psc (
        .clock (clock),
        .rst   (rst),
        .en    (en),
        .clr   (load),
        .tick  (w_tick)
    );

    assign w_up = (mode == MODE_BOUNCE) ? r_bdir : dir;

    always_comb begin
        w_next      = r_count;
        w_evt       = 1'b0;
        w_bdir_step = r_bdir;
        case (mode)
            MODE_SAT: begin
                if (w_up) begin
                    if (r_count != MAX) w_next = r_count + ONE;
                end else begin
                    if (r_count != '0) w_next = r_count - ONE;
                end
            end
            MODE_BOUNCE: begin
                if (r_bdir) begin
                    if (r_count == MAX) begin
                        w_next      = MAX - ONE;
                        w_bdir_step = 1'b0;
                        w_evt       = 1'b1;
                    end else begin
                        w_next = r_count + ONE;
                    end
                end else begin
                    if (r_count == '0) begin
                        w_next      = ONE;
                        w_bdir_step = 1'b1;
                        w_evt       = 1'b1;
                    end else begin
                        w_next = r_count - ONE;
                    end
                end
            end
            default: begin
                // 2'b11 falls through here and behaves as wrap.
                w_next = w_up ? r_count + ONE : r_count - ONE;
                w_evt  = w_up ? (r_count == MAX) : (r_count == '0);
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_evt   <= 1'b0;
            r_bdir  <= 1'b1;
        end else if (load) begin
            r_count <= load_val;
            r_evt   <= 1'b0;
            r_bdir  <= dir;
        end else begin
            r_evt <= w_tick && w_evt;
            if (w_tick) r_count <= w_next;
            // Outside bounce the stored direction tracks dir so bounce starts from it.
            if (mode != MODE_BOUNCE) r_bdir <= dir;
            else if (w_tick)         r_bdir <= w_bdir_step;
        end
    end

    assign count   = r_count;
    assign tick    = w_tick;
    assign evt     = r_evt;
    assign dir_eff = (mode == MODE_BOUNCE) ? r_bdir : dir;
    assign at_max  = (r_count == MAX);
    assign at_min  = (r_count == '0);

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// tb/tb_prescaled_updown_counter.sv - directed table, hand sequences and random checks vs a reference model
module tb_prescaled_updown_counter;

    localparam int W    = 6;
    localparam int MAXV = 63;

    logic         clock = 1'b0;
    logic         rst;
    logic         en;
    logic         dir;
    logic [1:0]   mode;
    logic         load;
    logic [W-1:0] load_val;

    logic [W-1:0] cnt_o  [2];
    logic         tick_o [2];
    logic         evt_o  [2];
    logic         de_o   [2];
    logic         amax_o [2];
    logic         amin_o [2];

    int total = 0;
    int bad   = 0;

    int divs  [2] = '{7, 1};
    int m_cnt [2];
    int m_psc [2];
    int m_bd  [2];
    int m_ev  [2];

    always #5 clock = ~clock;

    prescaled_updown_counter #(.WIDTH(W), .DIV(7)) u7 (
        .clock(clock), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_val(load_val), .count(cnt_o[0]), .tick(tick_o[0]), .evt(evt_o[0]),
        .dir_eff(de_o[0]), .at_max(amax_o[0]), .at_min(amin_o[0])
    );

    prescaled_updown_counter #(.WIDTH(W), .DIV(1)) u1 (
        .clock(clock), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_val(load_val), .count(cnt_o[1]), .tick(tick_o[1]), .evt(evt_o[1]),
        .dir_eff(de_o[1]), .at_max(amax_o[1]), .at_min(amin_o[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_psc[k] = 0; m_bd[k] = 1; m_ev[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        int  n;
        bit  tk;
        bit  up;
        int  md;
        tk = en && (m_psc[k] == divs[k] - 1);
        if (load) begin
            m_cnt[k] = int'(load_val); m_psc[k] = 0; m_bd[k] = dir; m_ev[k] = 0;
        end else begin
            m_ev[k] = 0;
            if (en) m_psc[k] = (m_psc[k] + 1) % divs[k];
            if (mode != 2'b10) m_bd[k] = dir;
            if (tk) begin
                md = (mode == 2'b11) ? 0 : int'(mode);
                up = (md == 2) ? m_bd[k][0] : dir;
                n  = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
                if (md == 0) begin
                    if (n > MAXV || n < 0) m_ev[k] = 1;
                    m_cnt[k] = (n + MAXV + 1) % (MAXV + 1);
                end else if (md == 1) begin
                    m_cnt[k] = (n > MAXV) ? MAXV : (n < 0) ? 0 : n;
                end else if (n > MAXV) begin
                    m_cnt[k] = MAXV - 1; m_bd[k] = 0; m_ev[k] = 1;
                end else if (n < 0) begin
                    m_cnt[k] = 1; m_bd[k] = 1; m_ev[k] = 1;
                end else begin
                    m_cnt[k] = n;
                end
            end
        end
    endtask

    // One clock: combinational outputs checked before the edge, registered ones just after.
    task automatic cycle();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("tick[%0d]", k), int'(tick_o[k]),
                int'(en && (m_psc[k] == divs[k] - 1)));
            chk($sformatf("dir_eff[%0d]", k), int'(de_o[k]),
                (mode == 2'b10) ? m_bd[k] : int'(dir));
        end
        @(posedge clock);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("count[%0d]", k), int'(cnt_o[k]), m_cnt[k]);
            chk($sformatf("evt[%0d]", k), int'(evt_o[k]), m_ev[k]);
            chk($sformatf("at_max[%0d]", k), int'(amax_o[k]), int'(m_cnt[k] == MAXV));
            chk($sformatf("at_min[%0d]", k), int'(amin_o[k]), int'(m_cnt[k] == 0));
        end
    endtask

    typedef struct {
        bit       en;
        bit       dir;
        bit [1:0] mode;
        bit       load;
        int       lv;
        int       cyc;
        int       exp_cnt;
        bit       exp_evt;
        bit       exp_de;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit e, bit d, bit [1:0] m, bit l, int lv, int cyc,
                                int c, bit ev, bit de);
        vec_t v;
        v.en = e; v.dir = d; v.mode = m; v.load = l; v.lv = lv; v.cyc = cyc;
        v.exp_cnt = c; v.exp_evt = ev; v.exp_de = de;
        return v;
    endfunction

    initial begin
        // Expectations for the DIV=7 instance, worked out by hand from the step rules.
        vecs.push_back(mk(1, 1, 2'b00, 0,  0,  6,  0, 0, 1));
        vecs.push_back(mk(1, 1, 2'b00, 0,  0,  1,  1, 0, 1));
        vecs.push_back(mk(1, 1, 2'b00, 0,  0,  7,  2, 0, 1));
        vecs.push_back(mk(1, 1, 2'b00, 1, 63,  1, 63, 0, 1));
        vecs.push_back(mk(1, 1, 2'b00, 0,  0,  7,  0, 1, 1));
        vecs.push_back(mk(1, 1, 2'b00, 0,  0,  1,  0, 0, 1));
        vecs.push_back(mk(1, 0, 2'b00, 1,  0,  1,  0, 0, 0));
        vecs.push_back(mk(1, 0, 2'b00, 0,  0,  7, 63, 1, 0));
        vecs.push_back(mk(1, 1, 2'b01, 1, 62,  1, 62, 0, 1));
        vecs.push_back(mk(1, 1, 2'b01, 0,  0,  7, 63, 0, 1));
        vecs.push_back(mk(1, 1, 2'b01, 0,  0,  7, 63, 0, 1));
        vecs.push_back(mk(1, 1, 2'b01, 0,  0, 14, 63, 0, 1));
        vecs.push_back(mk(1, 0, 2'b01, 0,  0,  7, 62, 0, 0));
        vecs.push_back(mk(1, 1, 2'b10, 1, 61,  1, 61, 0, 1));
        vecs.push_back(mk(1, 1, 2'b10, 0,  0,  7, 62, 0, 1));
        vecs.push_back(mk(1, 1, 2'b10, 0,  0,  7, 63, 0, 1));
        vecs.push_back(mk(1, 1, 2'b10, 0,  0,  7, 62, 1, 0));
        vecs.push_back(mk(1, 0, 2'b10, 0,  0,  7, 61, 0, 0));
        vecs.push_back(mk(1, 1, 2'b10, 0,  0,  7, 60, 0, 0));
        vecs.push_back(mk(1, 0, 2'b10, 1,  2,  1,  2, 0, 0));
        vecs.push_back(mk(1, 0, 2'b10, 0,  0,  7,  1, 0, 0));
        vecs.push_back(mk(1, 0, 2'b10, 0,  0,  7,  0, 0, 0));
        vecs.push_back(mk(1, 0, 2'b10, 0,  0,  7,  1, 1, 1));
        vecs.push_back(mk(1, 1, 2'b00, 1, 10,  1, 10, 0, 1));
        vecs.push_back(mk(1, 1, 2'b00, 0,  0,  3, 10, 0, 1));
        vecs.push_back(mk(1, 1, 2'b00, 1,  5,  1,  5, 0, 1));
        vecs.push_back(mk(1, 1, 2'b00, 0,  0,  6,  5, 0, 1));
        vecs.push_back(mk(1, 1, 2'b00, 0,  0,  1,  6, 0, 1));
        vecs.push_back(mk(1, 1, 2'b00, 0,  0,  3,  6, 0, 1));
        vecs.push_back(mk(0, 1, 2'b00, 0,  0, 10,  6, 0, 1));
        vecs.push_back(mk(1, 1, 2'b00, 0,  0,  3,  6, 0, 1));
        vecs.push_back(mk(1, 1, 2'b00, 0,  0,  1,  7, 0, 1));
        vecs.push_back(mk(0, 1, 2'b00, 1, 20,  1, 20, 0, 1));
        vecs.push_back(mk(0, 1, 2'b00, 0,  0,  5, 20, 0, 1));
        vecs.push_back(mk(1, 0, 2'b11, 1,  1,  1,  1, 0, 0));
        vecs.push_back(mk(1, 0, 2'b11, 0,  0,  7,  0, 0, 0));
        vecs.push_back(mk(1, 0, 2'b11, 0,  0,  7, 63, 1, 0));

        rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_count[%0d]", k), int'(cnt_o[k]), 0);
            chk($sformatf("rst_tick[%0d]", k), int'(tick_o[k]), 0);
            chk($sformatf("rst_evt[%0d]", k), int'(evt_o[k]), 0);
            chk($sformatf("rst_at_min[%0d]", k), int'(amin_o[k]), 1);
            chk($sformatf("rst_at_max[%0d]", k), int'(amax_o[k]), 0);
        end
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; dir = vecs[i].dir; mode = vecs[i].mode;
            load = vecs[i].load; load_val = W'(vecs[i].lv);
            repeat (vecs[i].cyc) cycle();
            chk($sformatf("vec%0d_count", i), int'(cnt_o[0]), vecs[i].exp_cnt);
            chk($sformatf("vec%0d_evt", i), int'(evt_o[0]), int'(vecs[i].exp_evt));
            chk($sformatf("vec%0d_dir_eff", i), int'(de_o[0]), int'(vecs[i].exp_de));
        end

        load = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            en   = ($urandom % 8) != 0;
            load = ($urandom % 24) == 0;
            case ($urandom % 5)
                0:       load_val = '0;
                1:       load_val = W'(1);
                2:       load_val = W'(MAXV - 1);
                3:       load_val = W'(MAXV);
                default: load_val = W'($urandom);
            endcase
            if (($urandom % 10) == 0) dir = ~dir;
            if (($urandom % 40) == 0) mode = 2'($urandom);
            cycle();
        end

        // Asynchronous reset between edges at count 40.
        en = 1'b1; dir = 1'b1; mode = 2'b00; load = 1'b1; load_val = W'(39);
        cycle();
        load = 1'b0;
        repeat (7) cycle();
        chk("pre_rst_count", int'(cnt_o[0]), 40);
        rst = 1'b1;
        #2;
        chk("async_count", int'(cnt_o[0]), 0);
        chk("async_evt", int'(evt_o[0]), 0);
        chk("async_at_min", int'(amin_o[0]), 1);
        chk("async_tick", int'(tick_o[0]), 0);
        model_reset();
        @(negedge clock);
        rst = 1'b0;
        repeat (6) cycle();
        chk("recover_hold", int'(cnt_o[0]), 0);
        chk("recover_div1", int'(cnt_o[1]), 6);
        cycle();
        chk("recover_first_step", int'(cnt_o[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
